// File: rtl/rn_pkg.sv
// Shared rename-stage constants and tag types.
// Free-list depth is the physical pool left after the identity map.
package rn_pkg;
  localparam int PREG_W   = 6;
  localparam int NAREG    = 32;
  localparam int FL_DEPTH = (1 << PREG_W) - NAREG;
  localparam int FL_IW    = $clog2(FL_DEPTH);

  typedef logic [PREG_W-1:0] ptag_t;

  localparam ptag_t P0 = '0;
endpackage

// File: rtl/rn_free_list.sv
// Circular free list: 2 pops and 2 pushes per cycle.
// retire_head tracks committed allocations for flush recovery.
module rn_free_list
  import rn_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] pop_cnt,
  input  logic       recover,
  input  logic       push1,
  input  logic       push2,
  input  ptag_t      push_tag1,
  input  ptag_t      push_tag2,
  input  logic [1:0] retire_cnt,
  output ptag_t      head_tag0,
  output ptag_t      head_tag1,
  output ptag_t      free_cnt
);
  ptag_t mem [FL_DEPTH];
  ptag_t head, tail, rhead;
  ptag_t rhead_nxt, tail_nxt;
  logic [FL_IW-1:0] hi0, hi1, ti0, ti1;

  assign hi0 = head[FL_IW-1:0];
  assign hi1 = hi0 + 1'b1;
  assign ti0 = tail[FL_IW-1:0];
  assign ti1 = ti0 + 1'b1;

  assign head_tag0 = mem[hi0];
  assign head_tag1 = mem[hi1];
  assign free_cnt  = tail - head;

  assign rhead_nxt = rhead + ptag_t'(retire_cnt);
  assign tail_nxt  = tail + ptag_t'(push1) + ptag_t'(push2);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < FL_DEPTH; k++)
        mem[k] <= ptag_t'(NAREG + k);
      head  <= '0;
      tail  <= ptag_t'(FL_DEPTH);
      rhead <= '0;
    end else begin
      // pushes are packed: cm1 first, gaps closed
      if (push1 && push2) begin
        mem[ti0] <= push_tag1;
        mem[ti1] <= push_tag2;
      end else if (push1) begin
        mem[ti0] <= push_tag1;
      end else if (push2) begin
        mem[ti0] <= push_tag2;
      end
      tail  <= tail_nxt;
      rhead <= rhead_nxt;
      head  <= recover ? rhead_nxt
                       : head + ptag_t'(pop_cnt);
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    (int'(push1) + int'(push2)) <=
    (FL_DEPTH - int'(free_cnt) + int'(pop_cnt)));
endmodule

// File: rtl/rn_rename2.sv
// 2-wide rename: speculative RAT, commit RAT, free list.
// Flush restores RAT from commit RAT and head from retire_head.
module rn_rename2
  import rn_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       i1_valid,
  input  logic       i2_valid,
  input  logic       i1_regw,
  input  logic       i2_regw,
  input  logic [4:0] i1_src1,
  input  logic [4:0] i1_src2,
  input  logic [4:0] i1_rdst,
  input  logic [4:0] i2_src1,
  input  logic [4:0] i2_src2,
  input  logic [4:0] i2_rdst,
  input  logic       dn_ready,
  output logic       stall_out,
  output logic       out_fire,
  output ptag_t      i1_psrc1,
  output ptag_t      i1_psrc2,
  output ptag_t      i1_pdst,
  output ptag_t      i1_old_pdst,
  output ptag_t      i2_psrc1,
  output ptag_t      i2_psrc2,
  output ptag_t      i2_pdst,
  output ptag_t      i2_old_pdst,
  input  logic       cm1_valid,
  input  logic       cm2_valid,
  input  logic [4:0] cm1_rdst,
  input  logic [4:0] cm2_rdst,
  input  ptag_t      cm1_pdst,
  input  ptag_t      cm1_old_pdst,
  input  ptag_t      cm2_pdst,
  input  ptag_t      cm2_old_pdst,
  output ptag_t      free_cnt
);
  ptag_t rat      [NAREG];
  ptag_t arat     [NAREG];
  ptag_t arat_nxt [NAREG];

  logic       a1, a2, any_v, fire;
  logic [1:0] need, pop_cnt, retire_cnt;
  logic       push1, push2;
  ptag_t      h0, h1;

  assign a1    = i1_valid & i1_regw & (i1_rdst != '0);
  assign a2    = i2_valid & i2_regw & (i2_rdst != '0);
  assign need  = {1'b0, a1} + {1'b0, a2};
  assign any_v = i1_valid | i2_valid;

  assign fire = any_v & dn_ready & ~flush &
                (free_cnt >= ptag_t'(need));
  assign out_fire  = fire;
  assign stall_out = any_v & ~fire;

  assign i1_pdst = a1 ? h0 : P0;
  assign i2_pdst = a2 ? (a1 ? h1 : h0) : P0;

  assign i1_psrc1 = (i1_src1 == '0) ? P0 : rat[i1_src1];
  assign i1_psrc2 = (i1_src2 == '0) ? P0 : rat[i1_src2];
  assign i1_old_pdst = a1 ? rat[i1_rdst] : P0;

  // slot 2 sees slot 1's new mapping within the group
  assign i2_psrc1 = (i2_src1 == '0) ? P0 :
                    (a1 && i2_src1 == i1_rdst) ? i1_pdst :
                    rat[i2_src1];
  assign i2_psrc2 = (i2_src2 == '0) ? P0 :
                    (a1 && i2_src2 == i1_rdst) ? i1_pdst :
                    rat[i2_src2];
  assign i2_old_pdst = !a2 ? P0 :
                       (a1 && i2_rdst == i1_rdst) ? i1_pdst :
                       rat[i2_rdst];

  assign pop_cnt    = fire ? need : 2'd0;
  assign push1      = cm1_valid & (cm1_old_pdst != P0);
  assign push2      = cm2_valid & (cm2_old_pdst != P0);
  assign retire_cnt = {1'b0, cm1_valid} + {1'b0, cm2_valid};

  always_comb begin
    arat_nxt = arat;
    if (cm1_valid && cm1_rdst != '0)
      arat_nxt[cm1_rdst] = cm1_pdst;
    if (cm2_valid && cm2_rdst != '0)
      arat_nxt[cm2_rdst] = cm2_pdst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NAREG; k++) begin
        rat[k]  <= ptag_t'(k);
        arat[k] <= ptag_t'(k);
      end
    end else begin
      arat <= arat_nxt;
      if (flush) begin
        rat <= arat_nxt;
      end else if (fire) begin
        if (a1) rat[i1_rdst] <= i1_pdst;
        if (a2) rat[i2_rdst] <= i2_pdst;
      end
    end
  end

  rn_free_list u_fl (
    .clk        (clk),
    .rst        (rst),
    .pop_cnt    (pop_cnt),
    .recover    (flush),
    .push1      (push1),
    .push2      (push2),
    .push_tag1  (cm1_old_pdst),
    .push_tag2  (cm2_old_pdst),
    .retire_cnt (retire_cnt),
    .head_tag0  (h0),
    .head_tag1  (h1),
    .free_cnt   (free_cnt)
  );
endmodule

// File: tb/tb_rn_rename2.sv
// Directed bench for rn_rename2: lookup, bypass,
// exhaustion, zero-alloc and flush recovery.
module tb_rn_rename2;
  import rn_pkg::*;

  logic clk = 1'b0;
  logic rst, flush, dn_ready;
  logic i1_valid, i2_valid, i1_regw, i2_regw;
  logic [4:0] i1_src1, i1_src2, i1_rdst;
  logic [4:0] i2_src1, i2_src2, i2_rdst;
  logic stall_out, out_fire;
  ptag_t i1_psrc1, i1_psrc2, i1_pdst, i1_old_pdst;
  ptag_t i2_psrc1, i2_psrc2, i2_pdst, i2_old_pdst;
  logic cm1_valid, cm2_valid;
  logic [4:0] cm1_rdst, cm2_rdst;
  ptag_t cm1_pdst, cm1_old_pdst, cm2_pdst, cm2_old_pdst;
  ptag_t free_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rn_rename2 dut (
    .clk(clk), .rst(rst), .flush(flush),
    .i1_valid(i1_valid), .i2_valid(i2_valid),
    .i1_regw(i1_regw), .i2_regw(i2_regw),
    .i1_src1(i1_src1), .i1_src2(i1_src2),
    .i1_rdst(i1_rdst),
    .i2_src1(i2_src1), .i2_src2(i2_src2),
    .i2_rdst(i2_rdst),
    .dn_ready(dn_ready),
    .stall_out(stall_out), .out_fire(out_fire),
    .i1_psrc1(i1_psrc1), .i1_psrc2(i1_psrc2),
    .i1_pdst(i1_pdst), .i1_old_pdst(i1_old_pdst),
    .i2_psrc1(i2_psrc1), .i2_psrc2(i2_psrc2),
    .i2_pdst(i2_pdst), .i2_old_pdst(i2_old_pdst),
    .cm1_valid(cm1_valid), .cm2_valid(cm2_valid),
    .cm1_rdst(cm1_rdst), .cm2_rdst(cm2_rdst),
    .cm1_pdst(cm1_pdst), .cm1_old_pdst(cm1_old_pdst),
    .cm2_pdst(cm2_pdst), .cm2_old_pdst(cm2_old_pdst),
    .free_cnt(free_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    flush = 0; dn_ready = 1;
    i1_valid = 0; i1_regw = 0;
    i1_src1 = 0; i1_src2 = 0; i1_rdst = 0;
    i2_valid = 0; i2_regw = 0;
    i2_src1 = 0; i2_src2 = 0; i2_rdst = 0;
    cm1_valid = 0; cm1_rdst = 0;
    cm1_pdst = 0; cm1_old_pdst = 0;
    cm2_valid = 0; cm2_rdst = 0;
    cm2_pdst = 0; cm2_old_pdst = 0;
  endtask

  task automatic s1(input logic v, input logic w,
                    input logic [4:0] a, input logic [4:0] b,
                    input logic [4:0] d);
    i1_valid = v; i1_regw = w;
    i1_src1 = a; i1_src2 = b; i1_rdst = d;
  endtask

  task automatic s2(input logic v, input logic w,
                    input logic [4:0] a, input logic [4:0] b,
                    input logic [4:0] d);
    i2_valid = v; i2_regw = w;
    i2_src1 = a; i2_src2 = b; i2_rdst = d;
  endtask

  task automatic do_reset();
    clr();
    rst = 1;
    tick();
    tick();
    rst = 0;
    #1;
  endtask

  initial begin
    do_reset();
    chk("rst_stall", stall_out, 0);
    chk("rst_fire", out_fire, 0);
    chk("rst_free", free_cnt, 32);
    i1_src1 = 5; i1_src2 = 9; #1;
    chk("rst_id5", i1_psrc1, 5);
    chk("rst_id9", i1_psrc2, 9);

    // single rename r3 <- r1,r2
    clr(); s1(1, 1, 1, 2, 3); #1;
    chk("t1_ps1", i1_psrc1, 1);
    chk("t1_ps2", i1_psrc2, 2);
    chk("t1_pd", i1_pdst, 32);
    chk("t1_old", i1_old_pdst, 3);
    chk("t1_i2pd", i2_pdst, 0);
    chk("t1_fire", out_fire, 1);
    chk("t1_stall", stall_out, 0);
    tick();
    clr(); i1_src1 = 3; #1;
    chk("t1_rat3", i1_psrc1, 32);
    chk("t1_free", free_cnt, 31);

    // intra-group source bypass
    do_reset();
    s1(1, 1, 1, 1, 5); s2(1, 1, 5, 5, 6); #1;
    chk("bp_i1pd", i1_pdst, 32);
    chk("bp_i1old", i1_old_pdst, 5);
    chk("bp_ps1", i2_psrc1, 32);
    chk("bp_ps2", i2_psrc2, 32);
    chk("bp_i2pd", i2_pdst, 33);
    chk("bp_i2old", i2_old_pdst, 6);
    tick();

    // same rdst in both slots
    do_reset();
    s1(1, 1, 0, 0, 7); s2(1, 1, 0, 0, 7); #1;
    chk("wa_i1old", i1_old_pdst, 7);
    chk("wa_i2old", i2_old_pdst, 32);
    tick();
    clr(); i1_src1 = 7; #1;
    chk("wa_rat7", i1_psrc1, 33);
    chk("wa_free", free_cnt, 30);

    // exhaustion
    do_reset();
    for (int k = 0; k < 16; k++) begin
      s1(1, 1, 0, 0, 4); s2(1, 1, 0, 0, 5); #1;
      chk("ex_p1", i1_pdst, 32 + 2 * k);
      chk("ex_p2", i2_pdst, 33 + 2 * k);
      chk("ex_fire", out_fire, 1);
      tick();
    end
    clr(); #1;
    chk("ex_free0", free_cnt, 0);
    s1(1, 1, 0, 0, 4); s2(1, 1, 0, 0, 5); #1;
    chk("ex_stall", stall_out, 1);
    chk("ex_nofire", out_fire, 0);
    tick();
    clr(); i1_src1 = 4; i1_src2 = 5; #1;
    chk("ex_rat4", i1_psrc1, 62);
    chk("ex_rat5", i1_psrc2, 63);

    // no-alloc slots at empty free list
    s1(1, 1, 0, 0, 0); s2(1, 0, 0, 0, 3); #1;
    chk("za_fire", out_fire, 1);
    chk("za_stall", stall_out, 0);
    chk("za_p1", i1_pdst, 0);
    chk("za_p2", i2_pdst, 0);
    chk("za_old2", i2_old_pdst, 0);
    tick();
    clr(); #1;
    chk("za_free", free_cnt, 0);

    // one commit frees p4
    cm1_valid = 1; cm1_rdst = 4;
    cm1_pdst = 32; cm1_old_pdst = 4;
    tick();
    clr(); #1;
    chk("cm_free1", free_cnt, 1);
    s1(1, 1, 0, 0, 6); s2(1, 1, 0, 0, 7); #1;
    chk("cm_dual_stall", stall_out, 1);
    s2(0, 0, 0, 0, 0); #1;
    chk("cm_fire", out_fire, 1);
    chk("cm_pd4", i1_pdst, 4);
    tick();
    clr(); #1;
    chk("cm_free0", free_cnt, 0);

    // flush after two of four commit
    do_reset();
    s1(1, 1, 0, 0, 1); s2(1, 1, 0, 0, 2);
    tick();
    s1(1, 1, 0, 0, 3); s2(1, 1, 0, 0, 4); #1;
    chk("fl_p34", i1_pdst, 34);
    chk("fl_p35", i2_pdst, 35);
    tick();
    clr();
    cm1_valid = 1; cm1_rdst = 1;
    cm1_pdst = 32; cm1_old_pdst = 1;
    cm2_valid = 1; cm2_rdst = 2;
    cm2_pdst = 33; cm2_old_pdst = 2;
    tick();
    clr(); flush = 1; s1(1, 1, 0, 0, 9); #1;
    chk("fl_nofire", out_fire, 0);
    chk("fl_stall", stall_out, 1);
    tick();
    clr(); i1_src1 = 1; i1_src2 = 2;
    i2_src1 = 3; i2_src2 = 4; #1;
    chk("fl_r1", i1_psrc1, 32);
    chk("fl_r2", i1_psrc2, 33);
    chk("fl_r3", i2_psrc1, 3);
    chk("fl_r4", i2_psrc2, 4);
    chk("fl_free", free_cnt, 32);
    clr(); s1(1, 1, 0, 0, 5); #1;
    chk("fl_next", i1_pdst, 34);
    dn_ready = 0; #1;
    chk("fl_dnstall", stall_out, 1);
    tick();

    // flush with same-cycle commit
    do_reset();
    s1(1, 1, 0, 0, 8); s2(1, 1, 0, 0, 9);
    tick();
    clr(); flush = 1;
    cm1_valid = 1; cm1_rdst = 8;
    cm1_pdst = 32; cm1_old_pdst = 8;
    tick();
    clr(); i1_src1 = 8; i1_src2 = 9; #1;
    chk("fc_r8", i1_psrc1, 32);
    chk("fc_r9", i1_psrc2, 9);
    chk("fc_free", free_cnt, 32);
    clr(); s1(1, 1, 0, 0, 10); #1;
    chk("fc_next", i1_pdst, 33);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
